game_turn_ctrl: RTL and testbench
=================================

// Module: game_turn_ctrl
// PURPOSE
//  Turn sequencer for the 2048 datapath; owns the board-update handshakes.
//  New game: pulses board clear, then runs two tile spawns.
//  Each accepted move: runs the slide/merge unit; if the board changed, runs one
//  spawn; then evaluates win/lose.
//  The board register lives outside; this block only reads a board snapshot and
//  issues start pulses.
// PARAMETERS
//  WIN_VALUE    12'd2048  tile value that sets game_won
//  CNT_W        16        width of turn_count
//  WDOG_CYCLES  64        wait-state timeout (only with GAME_WDOG_EN)
// PORTS
//  clk            in   1          system clock
//  rst            in   1          synchronous, active-high reset
//  new_game       in   1          pulse: start a new game (accepted in any state)
//  move_valid     in   1          move request valid
//  move_dir       in   2          0=up 1=down 2=left 3=right
//  move_ready     out  1          high only in IDLE
//  board_in       in   12[4][4]   current board snapshot
//  clear_board    out  1          1-cycle pulse: board register <= all zero
//  slide_start    out  1          1-cycle pulse to slide/merge unit
//  slide_dir      out  2          direction latched at move acceptance
//  slide_done     in   1          slide unit finished
//  slide_changed  in   1          qualified by slide_done: board changed
//  spawn_start    out  1          1-cycle pulse to random-tile unit
//  spawn_done     in   1          random-tile unit finished
//  game_won       out  1          sticky until new_game/rst
//  game_over      out  1          sticky until new_game/rst
//  turn_count     out  CNT_W      accepted moves that changed the board
//  wdog_err       out  1          sticky timeout flag (0 when macro off)
// BEHAVIOUR
//  Reset values
//   - State NEW_WAIT.
//   - All outputs 0; slide_dir=0; turn_count=0.
//  States
//   - NEW_WAIT: waits for new_game.
//   - CLR: clear_board=1 for 1 cycle; spawn_cnt=2.
//   - SPN_REQ:
//     - If board_in has no zero cell: skip the spawn, go CHK.
//     - Else spawn_start=1, go SPN_WAIT.
//   - SPN_WAIT: on spawn_done, spawn_cnt-1.
//     - If spawn_cnt is now nonzero: SPN_REQ. Else CHK.
//   - IDLE: move_ready=1.
//     - On move_valid: latch move_dir, go SLD_REQ.
//   - SLD_REQ: slide_start=1, go SLD_WAIT.
//   - SLD_WAIT: on slide_done:
//     - slide_changed=1: turn_count+1 (wraps at 2^CNT_W), spawn_cnt=1, SPN_REQ.
//     - slide_changed=0: IDLE. No spawn, no count.
//   - CHK: 1 cycle, combinational scan of board_in.
//     - Any tile >= WIN_VALUE: game_won=1, go DONE.
//     - Else no zero cell and no horizontally/vertically adjacent equal pair:
//       game_over=1, go DONE.
//     - Else IDLE.
//   - DONE: move_ready=0; waits for new_game.
//  Handshake rules
//   - done inputs are sampled only in their WAIT state; elsewhere ignored.
//   - Start pulses are exactly 1 cycle.
//  new_game
//   - Preempts any state, including mid-handshake.
//   - Next cycle: state CLR; flags and turn_count cleared.
//   - A late done from the aborted op must not be counted; CLR/SPN_REQ ignore done.
//  Boundary / priority
//   - move_valid && new_game in the same cycle: new_game wins; move dropped.
//   - WIN and LOSE both true in CHK: game_won takes priority; game_over stays 0.
//   - rst mid-operation: return to reset values next edge.
// CONFIGURATION
//  GAME_WDOG_EN defined
//   - Counter restarts on entry to SLD_WAIT/SPN_WAIT.
//   - After WDOG_CYCLES cycles without done: wdog_err=1 (sticky), go DONE.
//  GAME_WDOG_EN undefined
//   - No counter; WAIT states wait forever; wdog_err tied 0.
// STRUCTURE
//  game_pkg
//   - board_t typedef (logic [11:0] [3:0][3:0]).
//   - dir_t enum (UP, DOWN, LEFT, RIGHT).
//   - ctrl_state_t enum.
//   - WIN_VALUE default constant.
//  Sub-module board_status (combinational)
//   - In: board_in. Out: has_empty, has_win, can_merge.
//   - Instantiated once; has_empty also feeds the SPN_REQ skip.
// TESTING
//  1. rst, then new_game (spawn unit: done 3 cycles after start)
//     -> clear_board 1 pulse, 2 spawn_start pulses, then move_ready=1.
//  2. move_valid dir=2, slide_changed=1
//     -> slide_dir=2; 1 spawn_start; turn_count 0->1.
//  3. slide_done with slide_changed=0 -> no spawn_start; turn_count unchanged;
//     back to IDLE.
//  4. board full, no equal neighbours, after slide -> SPN_REQ skips spawn;
//     game_over=1; move_ready stays 0.
//  5. board contains 2048 and is full -> game_won=1, game_over=0.
//  6. new_game during SLD_WAIT, then stale slide_done
//     -> CLR runs; turn_count=0; stale done ignored.
//     With GAME_WDOG_EN, withheld spawn_done -> wdog_err after 64 cycles.

Source files
------------

// File: rtl/game_turn_ctrl_pkg.sv
// Shared types for the 2048 turn controller: board layout, move directions, FSM states.
package game_pkg;

   localparam logic [11:0] WIN_VALUE_DFLT = 12'd2048;

   // board[row][col] is one 12-bit tile value; 0 means an empty cell
   typedef logic [3:0][3:0][11:0] board_t;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic [3:0] {
      NEW_WAIT,
      CLR,
      SPN_REQ,
      SPN_WAIT,
      IDLE,
      SLD_REQ,
      SLD_WAIT,
      CHK,
      DONE
   } ctrl_state_t;

endpackage

// File: rtl/game_turn_ctrl_board_status.sv
// board_status: combinational scan of a board snapshot for empty cells, a winning tile
// and any horizontally/vertically adjacent equal pair.
module board_status
   import game_pkg::*;
#(
   parameter logic [11:0] WIN_VALUE = WIN_VALUE_DFLT
) (
   input  board_t board_in,
   output logic   has_empty,
   output logic   has_win,
   output logic   can_merge
);

   always_comb begin
      has_empty = 1'b0;
      has_win   = 1'b0;
      can_merge = 1'b0;
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned c = 0; c < 4; c++) begin
            if (board_in[r][c] == 12'd0)      has_empty = 1'b1;
            if (board_in[r][c] >= WIN_VALUE)  has_win   = 1'b1;
         end
      end
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned c = 0; c < 3; c++) begin
            if (board_in[r][c] == board_in[r][c+1]) can_merge = 1'b1;
         end
      end
      for (int unsigned r = 0; r < 3; r++) begin
         for (int unsigned c = 0; c < 4; c++) begin
            if (board_in[r][c] == board_in[r+1][c]) can_merge = 1'b1;
         end
      end
   end

endmodule

// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: 2048 turn sequencer driving clear/slide/spawn handshakes and win/lose flags.
// Optional wait-state watchdog is built when GAME_WDOG_EN is defined.
module game_turn_ctrl
   import game_pkg::*;
#(
   parameter logic [11:0] WIN_VALUE = WIN_VALUE_DFLT,
   parameter int unsigned CNT_W     = 16
`ifdef GAME_WDOG_EN
   ,
   parameter int unsigned WDOG_CYCLES = 64
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             new_game,
   input  logic             move_valid,
   input  logic [1:0]       move_dir,
   output logic             move_ready,
   input  board_t           board_in,
   output logic             clear_board,
   output logic             slide_start,
   output logic [1:0]       slide_dir,
   input  logic             slide_done,
   input  logic             slide_changed,
   output logic             spawn_start,
   input  logic             spawn_done,
   output logic             game_won,
   output logic             game_over,
   output logic [CNT_W-1:0] turn_count,
   output logic             wdog_err
);

   ctrl_state_t state, state_nx;
   logic [1:0]  spawn_cnt;
   dir_t        dir_q;
   logic        has_empty, has_win, can_merge;

   board_status #(.WIN_VALUE(WIN_VALUE)) u_status (
      .board_in  (board_in),
      .has_empty (has_empty),
      .has_win   (has_win),
      .can_merge (can_merge)
   );

   assign slide_dir = dir_q;

`ifdef GAME_WDOG_EN
   localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
   logic [WDOG_W-1:0] wdog_cnt;
   logic              in_wait, wdog_hit;

   // A done arriving on the final cycle still wins over the timeout
   assign in_wait  = (state == SLD_WAIT && !slide_done) || (state == SPN_WAIT && !spawn_done);
   assign wdog_hit = in_wait && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt <= '0;
         wdog_err <= 1'b0;
      end else begin
         wdog_cnt <= (in_wait && state_nx == state) ? wdog_cnt + 1'b1 : '0;
         if (new_game)      wdog_err <= 1'b0;
         else if (wdog_hit) wdog_err <= 1'b1;
      end
   end
`else
   assign wdog_err = 1'b0;
`endif

   always_comb begin
      state_nx    = state;
      move_ready  = 1'b0;
      clear_board = 1'b0;
      slide_start = 1'b0;
      spawn_start = 1'b0;
      case (state)
         NEW_WAIT: ;
         CLR: begin
            clear_board = 1'b1;
            state_nx    = SPN_REQ;
         end
         SPN_REQ: begin
            if (!has_empty) begin
               state_nx = CHK;
            end else begin
               spawn_start = 1'b1;
               state_nx    = SPN_WAIT;
            end
         end
         SPN_WAIT: if (spawn_done) state_nx = ((spawn_cnt - 2'd1) != 2'd0) ? SPN_REQ : CHK;
         IDLE: begin
            move_ready = 1'b1;
            if (move_valid) state_nx = SLD_REQ;
         end
         SLD_REQ: begin
            slide_start = 1'b1;
            state_nx    = SLD_WAIT;
         end
         SLD_WAIT: if (slide_done) state_nx = slide_changed ? SPN_REQ : IDLE;
         CHK:      state_nx = (has_win || (!has_empty && !can_merge)) ? DONE : IDLE;
         DONE: ;
         default:  state_nx = NEW_WAIT;
      endcase
`ifdef GAME_WDOG_EN
      if (wdog_hit) state_nx = DONE;
`endif
      if (new_game) state_nx = CLR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= NEW_WAIT;
         spawn_cnt  <= '0;
         dir_q      <= UP;
         turn_count <= '0;
         game_won   <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         state <= state_nx;
         if (new_game) begin
            turn_count <= '0;
            game_won   <= 1'b0;
            game_over  <= 1'b0;
         end else begin
            case (state)
               CLR:      spawn_cnt <= 2'd2;
               IDLE:     if (move_valid) dir_q <= dir_t'(move_dir);
               SLD_WAIT: begin
                  if (slide_done && slide_changed) begin
                     turn_count <= turn_count + 1'b1;
                     spawn_cnt  <= 2'd1;
                  end
               end
               SPN_WAIT: if (spawn_done) spawn_cnt <= spawn_cnt - 2'd1;
               CHK: begin
                  if (has_win)                      game_won  <= 1'b1;
                  else if (!has_empty && !can_merge) game_over <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Bench for game_turn_ctrl: emulated board/slide/spawn units, a vector table,
// randomized moves against a rule-level model, and hand-written abort sequences.
module tb_game_turn_ctrl;
   import game_pkg::*;

   logic        clk = 1'b0;
   logic        rst, new_game, move_valid;
   logic [1:0]  move_dir;
   logic        slide_done = 1'b0, slide_changed = 1'b0, spawn_done = 1'b0;
   board_t      brd = '0;
   logic        move_ready, clear_board, slide_start, spawn_start;
   logic        game_won, game_over, wdog_err;
   logic [1:0]  slide_dir;
   logic [15:0] turn_count;

   always #5 clk = ~clk;

   game_turn_ctrl #(.WIN_VALUE(12'd2048), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
      .move_dir(move_dir), .move_ready(move_ready), .board_in(brd),
      .clear_board(clear_board), .slide_start(slide_start), .slide_dir(slide_dir),
      .slide_done(slide_done), .slide_changed(slide_changed),
      .spawn_start(spawn_start), .spawn_done(spawn_done),
      .game_won(game_won), .game_over(game_over), .turn_count(turn_count),
      .wdog_err(wdog_err)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- environment: board register, slide unit, spawn unit ----------------
   int     n_clear = 0, n_spawn = 0, n_slide = 0;
   int     spn_t = 0, sld_t = 0, slide_lat = 2;
   bit     sld_chg = 0, next_chg = 0, hold_spawn = 0;
   board_t slide_result = '0;

   // spawn unit puts a 2 in the first empty cell (row-major)
   function automatic board_t place2(input board_t b);
      board_t o = b;
      bit     put = 0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!put && o[r][c] == 12'd0) begin o[r][c] = 12'd2; put = 1; end
      return o;
   endfunction

   always @(negedge clk) begin
      spawn_done    = 1'b0;
      slide_done    = 1'b0;
      slide_changed = 1'($urandom);   // garbage unless qualified by slide_done
      if (clear_board) begin brd = '0; n_clear++; end
      if (spn_t > 0) begin
         spn_t--;
         if (spn_t == 0 && !hold_spawn) begin spawn_done = 1'b1; brd = place2(brd); end
      end
      if (spawn_start) begin n_spawn++; spn_t = 3; end
      if (sld_t > 0) begin
         sld_t--;
         if (sld_t == 0) begin
            slide_done    = 1'b1;
            slide_changed = sld_chg;
            if (sld_chg) brd = slide_result;
         end
      end
      if (slide_start) begin n_slide++; sld_t = slide_lat; sld_chg = next_chg; end
   end

   // ---------------- rule-level model helpers ----------------
   function automatic void judge(input board_t b, output bit full, output bit win, output bit merge);
      full = 1; win = 0; merge = 0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (b[r][c] == 12'd0)     full = 0;
            if (b[r][c] >= 12'd2048)  win  = 1;
         end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++) if (b[r][c] == b[r][c+1]) merge = 1;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++) if (b[r][c] == b[r+1][c]) merge = 1;
   endfunction

   // checkerboard of 2/4 (full, no merges) or all-zero, with one cell overridden
   function automatic board_t mk(input bit chkr, input int mr, input int mc, input logic [11:0] mv);
      board_t b;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            b[r][c] = chkr ? (((r + c) % 2 == 0) ? 12'd2 : 12'd4) : 12'd0;
      b[mr][mc] = mv;
      return b;
   endfunction

   function automatic board_t gen_board();
      board_t b;
      int     mode = int'($urandom % 3);
      logic [11:0] pick [5];
      pick[0] = 12'd0; pick[1] = 12'd2048; pick[2] = 12'd8; pick[3] = 12'd2; pick[4] = 12'd4;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            case (mode)
               0:       b[r][c] = 12'd2 << ($urandom % 3);
               1:       b[r][c] = ((r + c) % 2 == 0) ? 12'd2 : 12'd4;
               default: b[r][c] = ($urandom % 2) ? 12'd0 : (12'd2 << ($urandom % 11));
            endcase
      if (mode == 1) b[$urandom % 4][$urandom % 4] = pick[$urandom % 5];
      return b;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic settle(input string nm);
      int n = 0;
      while (!(move_ready || game_won || game_over) && n < 400) begin @(negedge clk); n++; end
      if (!(move_ready || game_won || game_over)) begin
         checks++; errors++;
         $display("FAIL %s_timeout: not settled after %0d cycles", nm, n);
      end
   endtask

   task automatic pulse_new_game();
      @(negedge clk); new_game = 1'b1;
      @(negedge clk); new_game = 1'b0;
   endtask

   task automatic do_move(input logic [1:0] d, input bit chg, input board_t res);
      slide_result = res;
      next_chg     = chg;
      @(negedge clk); move_valid = 1'b1; move_dir = d;
      @(negedge clk); move_valid = 1'b0;
   endtask

   typedef struct {
      bit chkr; int mr; int mc; logic [11:0] mv; bit chg; logic [1:0] dir;
      int sp; bit won; bit over; bit rdy;
   } vec_t;
   vec_t tbl [9];

   int     c0, s0, l0, exp_turns, n;
   bit     exp_end, f, w, m;
   bit     chg_r, esp, ewon, eover;
   logic [1:0] d_r;
   board_t mb, res;

   initial begin
      tbl[0] = '{1, 0, 0, 12'd2,    1, 2'd0, 0, 0, 1, 0};  // full, no pair: lose
      tbl[1] = '{1, 0, 0, 12'd2048, 1, 2'd1, 0, 1, 0, 0};  // full with 2048: win beats lose
      tbl[2] = '{1, 0, 0, 12'd2047, 1, 2'd2, 0, 0, 1, 0};  // just below win value
      tbl[3] = '{1, 0, 0, 12'd4,    1, 2'd3, 0, 0, 0, 1};  // full but a pair exists
      tbl[4] = '{1, 1, 1, 12'd0,    1, 2'd0, 1, 0, 1, 0};  // spawn fills last hole, then lose
      tbl[5] = '{1, 1, 2, 12'd0,    1, 2'd1, 1, 0, 0, 1};  // spawn fills last hole, pair created
      tbl[6] = '{0, 2, 2, 12'd2048, 1, 2'd2, 1, 1, 0, 0};  // win with empties
      tbl[7] = '{1, 0, 0, 12'd2,    0, 2'd3, 0, 0, 0, 1};  // unchanged slide: no check
      tbl[8] = '{0, 0, 0, 12'd2,    1, 2'd1, 1, 0, 0, 1};

      rst = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_dir = 2'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready", move_ready, 0);   chk("rst_clear", clear_board, 0);
      chk("rst_slide", slide_start, 0);  chk("rst_spawn", spawn_start, 0);
      chk("rst_won", game_won, 0);       chk("rst_over", game_over, 0);
      chk("rst_wdog", wdog_err, 0);      chk("rst_dir", slide_dir, 0);
      chk("rst_turns", turn_count, 0);

      rst = 1'b0; move_valid = 1'b1; move_dir = 2'd3;
      repeat (4) @(negedge clk);
      move_valid = 1'b0;
      chk("newwait_slide", n_slide, 0);
      chk("newwait_ready", move_ready, 0);

      // new game: one clear, two spawns, then ready
      c0 = n_clear; s0 = n_spawn;
      pulse_new_game(); settle("ng1");
      chk("ng_clear", n_clear - c0, 1);  chk("ng_spawns", n_spawn - s0, 2);
      chk("ng_ready", move_ready, 1);    chk("ng_turns", turn_count, 0);

      // changed move left
      s0 = n_spawn;
      do_move(2'd2, 1, mk(0, 0, 0, 12'd4)); settle("mv_left");
      chk("left_dir", slide_dir, 2);     chk("left_spawns", n_spawn - s0, 1);
      chk("left_turns", turn_count, 1);  chk("left_ready", move_ready, 1);

      // unchanged move
      s0 = n_spawn;
      do_move(2'd0, 0, mk(0, 0, 0, 12'd2)); settle("mv_nochg");
      chk("nochg_spawns", n_spawn - s0, 0); chk("nochg_turns", turn_count, 1);
      chk("nochg_ready", move_ready, 1);    chk("nochg_dir", slide_dir, 0);

      exp_turns = 1; exp_end = 0;
      foreach (tbl[i]) begin
         if (exp_end) begin pulse_new_game(); settle("tbl_ng"); exp_turns = 0; end
         s0 = n_spawn;
         do_move(tbl[i].dir, tbl[i].chg, mk(tbl[i].chkr, tbl[i].mr, tbl[i].mc, tbl[i].mv));
         settle($sformatf("tbl%0d", i));
         exp_turns += int'(tbl[i].chg);
         exp_end = tbl[i].won || tbl[i].over;
         chk($sformatf("tbl%0d_spawns", i), n_spawn - s0, tbl[i].sp);
         chk($sformatf("tbl%0d_won", i), game_won, tbl[i].won);
         chk($sformatf("tbl%0d_over", i), game_over, tbl[i].over);
         chk($sformatf("tbl%0d_ready", i), move_ready, tbl[i].rdy);
         chk($sformatf("tbl%0d_turns", i), turn_count, exp_turns);
         chk($sformatf("tbl%0d_dir", i), slide_dir, tbl[i].dir);
      end

      // randomized moves against the model
      exp_end = 1;
      for (int it = 0; it < 60; it++) begin
         if (exp_end) begin
            pulse_new_game(); settle("rnd_ng");
            mb = place2(place2('0)); exp_turns = 0;
         end
         d_r = 2'($urandom); chg_r = 1'($urandom); res = gen_board();
         slide_lat = 1 + int'($urandom % 4);
         esp = 0; ewon = 0; eover = 0;
         if (chg_r) begin
            mb = res;
            judge(mb, f, w, m);
            if (!f) begin mb = place2(mb); esp = 1; end
            judge(mb, f, w, m);
            ewon = w; eover = !w && f && !m;
         end
         exp_turns += int'(chg_r);
         exp_end = ewon || eover;
         s0 = n_spawn;
         do_move(d_r, chg_r, res); settle("rnd");
         chk($sformatf("rnd%0d_spawns", it), n_spawn - s0, int'(esp));
         chk($sformatf("rnd%0d_won", it), game_won, ewon);
         chk($sformatf("rnd%0d_over", it), game_over, eover);
         chk($sformatf("rnd%0d_ready", it), move_ready, !exp_end);
         chk($sformatf("rnd%0d_turns", it), turn_count, exp_turns);
         chk($sformatf("rnd%0d_dir", it), slide_dir, d_r);
      end
      slide_lat = 2;

      // new_game and move_valid together: move dropped
      if (game_won || game_over) begin pulse_new_game(); settle("a_ng"); end
      do_move(2'd3, 1, mk(0, 3, 3, 12'd8)); settle("a_pre");
      c0 = n_clear; s0 = n_spawn; l0 = n_slide;
      @(negedge clk); new_game = 1'b1; move_valid = 1'b1; move_dir = 2'd1;
      @(negedge clk); new_game = 1'b0; move_valid = 1'b0;
      settle("a_ng2");
      chk("both_slides", n_slide - l0, 0);  chk("both_clear", n_clear - c0, 1);
      chk("both_spawns", n_spawn - s0, 2);  chk("both_turns", turn_count, 0);
      chk("both_dir", slide_dir, 3);        chk("both_ready", move_ready, 1);

      // new_game during SLD_WAIT, stale slide_done lands in SPN_WAIT
      do_move(2'd2, 1, mk(0, 0, 0, 12'd4)); settle("b_pre");
      slide_lat = 6; c0 = n_clear; s0 = n_spawn;
      do_move(2'd0, 1, mk(0, 3, 3, 12'd2));
      @(negedge clk); new_game = 1'b1;
      @(negedge clk); new_game = 1'b0;
      settle("stale");
      repeat (10) @(negedge clk);
      chk("stale_turns", turn_count, 0);   chk("stale_clear", n_clear - c0, 1);
      chk("stale_spawns", n_spawn - s0, 2); chk("stale_ready", move_ready, 1);
      chk("stale_over", game_over, 0);

      // rst mid-operation
      slide_lat = 5; s0 = n_spawn; l0 = n_slide;
      do_move(2'd3, 1, mk(0, 1, 1, 12'd2));
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("mrst_dir", slide_dir, 0);       chk("mrst_turns", turn_count, 0);
      chk("mrst_ready", move_ready, 0);    chk("mrst_won", game_won, 0);
      repeat (10) @(negedge clk);
      chk("mrst_idle_ready", move_ready, 0);
      chk("mrst_spawns", n_spawn - s0, 0); chk("mrst_slides", n_slide - l0, 1);
      slide_lat = 2;

`ifdef GAME_WDOG_EN
      hold_spawn = 1;
      pulse_new_game();
      n = 0;
      while (!spawn_start && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (!wdog_err && n < 200) begin @(negedge clk); n++; end
      chk("wdog_cycles", n, 65);
      chk("wdog_err", wdog_err, 1);
      chk("wdog_ready", move_ready, 0);
      hold_spawn = 0;
      repeat (5) @(negedge clk);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end

endmodule
